markov_predictor_n: RTL and testbench
=====================================

Name: markov_predictor_n

Overview:
- Parametrised successor of the order-1 rock-paper-scissors Markov opponent.
- Learns user-move frequencies conditioned on the last ORDER rounds, where each round is a (user move, computer move) pair.
- Each round it emits the move that beats the most likely user move.
- Adds the following over the first generation:
  - configurable history depth and counter width;
  - self-clearing table init;
  - valid/ready round handshake;
  - illegal-move detection;
  - saturation handling;
  - a row-count observation port.

Parameters:
- ORDER, 1, history depth in rounds (1..3). ROWS = 9^ORDER contexts.
- COUNT_W, 8, width of each per-context, per-move counter.
- ROUND_W, 16, width of the round counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- move_valid  in  1  user move offered
- user_move  in  2  00 rock, 01 scissors, 10 paper, 11 illegal
- move_ready  out  1  block accepts a move; equals choice_valid
- choice  out  2  computer move for the current round, same encoding as user_move
- choice_valid  out  1  choice is stable and committed for this round
- illegal_move  out  1  one-cycle pulse when user_move=11 is accepted
- rounds  out  ROUND_W  count of legal rounds played; saturates at all-ones
- cur_counts  out  3*COUNT_W  counts of the current context row, {paper, scissors, rock}; valid while choice_valid

Behaviour:
- Table: ROWS x 3 counters, each COUNT_W bits. Context index ctx has width clog2(ROWS).
- Pair encoding: pair = user*3 + comp, giving 0..8.
- Context update: ctx_next = (ctx*9 + pair) mod ROWS.
- Random source: free-running mod-3 counter rnd (0, 1, 2, 0, ...), advancing every clock, reset value 0.
- States: INIT, IDLE, UPDATE, PREDICT.
- Reset, synchronous, overrides everything including mid-UPDATE or mid-PREDICT:
  - state = INIT, init index = 0, ctx = 0, hist_fill = 0, rounds = 0;
  - choice = 00, choice_valid = 0, move_ready = 0, illegal_move = 0, cur_counts = 0.
- INIT: clears one row per cycle for ROWS cycles, then goes to PREDICT.
  - Example: with ORDER=1, the first cycle with reset low is cycle 0. Rows are cleared in cycles 0-8, PREDICT is cycle 9, and choice_valid is 1 from cycle 10.
- PREDICT (1 cycle): reads row[ctx] into counts c0 (rock), c1 (scissors), c2 (paper).
  - If hist_fill < ORDER, or all counts are zero: predicted = rnd.
  - Single maximum: predicted = index of that maximum.
  - Two-way tie on the maximum: predicted = lower index if rnd[0]==0, else the higher index.
  - Three-way tie: predicted = rnd.
  - choice = beat(predicted), where rock->paper (10), scissors->rock (00), paper->scissors (01).
  - Registers choice and cur_counts, then goes to IDLE.
- IDLE: choice_valid = move_ready = 1, with choice and cur_counts held stable.
  - On move_valid & move_ready in cycle T with a legal move, the move is latched and state = UPDATE at T+1.
  - choice_valid drops at T+1 and returns at T+3 (PREDICT at T+2).
  - Sustained move_valid therefore completes one round per 3 cycles.
- Illegal move (11) in IDLE: accepted, illegal_move pulses at T+1, state stays IDLE.
  - No table, ctx, hist_fill, rounds or choice change.
- UPDATE (1 cycle):
  - If hist_fill == ORDER: row[ctx][user] increments by 1.
    - If the counter is already at max: saturation rule applies (see Optional Feature).
  - Always:
    - ctx = ctx_next using the latched user move and the current choice;
    - hist_fill = min(hist_fill+1, ORDER);
    - rounds increments, saturating.
  - Then goes to PREDICT.
- move_valid outside IDLE is ignored; no buffering.
- Arithmetic is unsigned. Comparisons use full COUNT_W width.

Optional Feature:
- Macro: MARKOV_DECAY_EN.
- Defined: when the target counter is at max (2^COUNT_W - 1), all three counters of that row are right-shifted by 1, then the target counter is incremented, all in the same UPDATE cycle.
- Undefined: the target counter holds at max and the other counters are unchanged.

Test Plan:
- Init timing: ORDER=1, reset high 2 cycles then low -> choice_valid=0 for cycles 0-9, then 1 at cycle 10; cur_counts=0; rounds=0.
- Learning: ORDER=1, user always plays rock (00) for 20 rounds -> from round 5 on, choice=10 every round; cur_counts rock field non-zero; rounds=20.
- Illegal move: in IDLE, drive user_move=11 -> illegal_move pulse 1 cycle; choice, rounds and cur_counts unchanged; move_ready stays 1.
- Saturation: COUNT_W=2, bench forces the user to repeat rock in context row 2 (rock/paper) 4 times.
  - With MARKOV_DECAY_EN, the fourth update gives cur_counts rock = 2 (3>>1+1).
  - Without it, rock stays 3.
- Reset mid-operation: assert reset during UPDATE -> next cycle move_ready=0 and rounds=0; full ROWS-cycle re-init; first prediction uses rnd (hist_fill=0).
- Throughput: move_valid held 1 with legal moves for 30 cycles -> exactly 10 handshakes; choice_valid pattern 1,0,0 repeating.

Source files
------------

// File: rtl/markov_predictor_n.sv
// Order-N rock-paper-scissors Markov opponent: learns user moves per (user, computer) history context.
// Build option: define MARKOV_DECAY_EN to halve a row instead of holding when its target counter saturates.
module markov_predictor_n #(
  parameter int ORDER   = 1,
  parameter int COUNT_W = 8,
  parameter int ROUND_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 move_valid,
  input  logic [1:0]           user_move,
  output logic                 move_ready,
  output logic [1:0]           choice,
  output logic                 choice_valid,
  output logic                 illegal_move,
  output logic [ROUND_W-1:0]   rounds,
  output logic [3*COUNT_W-1:0] cur_counts
);
  localparam int ROWS   = 9 ** ORDER;
  localparam int CTX_W  = $clog2(ROWS);
  localparam int WIDE_W = CTX_W + 4;
  localparam int HF_W   = $clog2(ORDER + 1);
  localparam int ROW_W  = 3 * COUNT_W;

  localparam logic [1:0] S_INIT    = 2'd0;
  localparam logic [1:0] S_IDLE    = 2'd1;
  localparam logic [1:0] S_UPDATE  = 2'd2;
  localparam logic [1:0] S_PREDICT = 2'd3;

  logic [1:0]         state_reg;
  logic [CTX_W-1:0]   init_idx_reg;
  logic [CTX_W-1:0]   ctx_reg;
  logic [CTX_W-1:0]   ctx_next;
  logic [HF_W-1:0]    hist_fill_reg;
  logic [ROUND_W-1:0] rounds_reg;
  logic [1:0]         choice_reg;
  logic [1:0]         choice_next;
  logic [1:0]         user_reg;
  logic [1:0]         rnd_reg;
  logic [ROW_W-1:0]   cur_counts_reg;
  logic               illegal_reg;
  logic               hist_full;

  logic [ROW_W-1:0]   mem [ROWS];
  logic [ROW_W-1:0]   rd_data_reg;
  logic [ROW_W-1:0]   byp_data_reg;
  logic               byp_reg;
  logic [ROW_W-1:0]   row_q;
  logic [ROW_W-1:0]   upd_row;
  logic [ROW_W-1:0]   wr_data;
  logic               wr_en;
  logic [CTX_W-1:0]   wr_addr;
  logic [CTX_W-1:0]   rd_addr;

  assign hist_full = (hist_fill_reg == HF_W'(ORDER));

  // Context shift: append the (user, computer) pair and drop the oldest round.
  logic [3:0]        pair;
  logic [WIDE_W-1:0] ctx_wide;
  assign pair     = {2'b00, user_reg} * 4'd3 + {2'b00, choice_reg};
  assign ctx_wide = WIDE_W'(ctx_reg) * WIDE_W'(9) + WIDE_W'(pair);
  assign ctx_next = CTX_W'(ctx_wide % WIDE_W'(ROWS));

  // The row of ctx is still held in cur_counts_reg during UPDATE, so no read is needed there.
  logic [2:0] sat_vec;
  logic       tgt_sat;
  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [COUNT_W-1:0] cnt;
    logic               tgt;
    assign cnt         = cur_counts_reg[gi*COUNT_W +: COUNT_W];
    assign tgt         = (user_reg == 2'(gi));
    assign sat_vec[gi] = tgt & (&cnt);
`ifdef MARKOV_DECAY_EN
    assign upd_row[gi*COUNT_W +: COUNT_W] = tgt_sat ? (cnt >> 1) + COUNT_W'(tgt)
                                                    : cnt + COUNT_W'(tgt);
`else
    assign upd_row[gi*COUNT_W +: COUNT_W] = (tgt && !(&cnt)) ? cnt + COUNT_W'(1) : cnt;
`endif
  end
  assign tgt_sat = |sat_vec;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ctx_reg;
    wr_data = upd_row;
    if (state_reg == S_INIT) begin
      wr_en   = !reset;
      wr_addr = init_idx_reg;
      wr_data = '0;
    end else if (state_reg == S_UPDATE && hist_full) begin
      wr_en = !reset;
    end
  end

  // UPDATE prefetches the next context's row; a same-row write is forwarded through the bypass.
  assign rd_addr = (state_reg == S_UPDATE) ? ctx_next : ctx_reg;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_reg  <= mem[rd_addr];
    byp_reg      <= wr_en && (wr_addr == rd_addr);
    byp_data_reg <= wr_data;
  end

  assign row_q = byp_reg ? byp_data_reg : rd_data_reg;

  logic [COUNT_W-1:0] c0, c1, c2;
  logic [1:0]         pred, lo_idx, hi_idx;
  assign c0 = row_q[0*COUNT_W +: COUNT_W];
  assign c1 = row_q[1*COUNT_W +: COUNT_W];
  assign c2 = row_q[2*COUNT_W +: COUNT_W];

  always_comb begin
    lo_idx = 2'd1;
    hi_idx = 2'd2;
    if (c0 == c1 && c0 > c2) begin
      lo_idx = 2'd0;
      hi_idx = 2'd1;
    end else if (c0 == c2 && c0 > c1) begin
      lo_idx = 2'd0;
      hi_idx = 2'd2;
    end
    pred = rnd_reg;
    if (!hist_full || (c0 == '0 && c1 == '0 && c2 == '0)) pred = rnd_reg;
    else if (c0 > c1 && c0 > c2) pred = 2'd0;
    else if (c1 > c0 && c1 > c2) pred = 2'd1;
    else if (c2 > c0 && c2 > c1) pred = 2'd2;
    else if (c0 == c1 && c1 == c2) pred = rnd_reg;
    else pred = rnd_reg[0] ? hi_idx : lo_idx;
  end

  always_comb begin
    choice_next = 2'd1;
    case (pred)
      2'd0:    choice_next = 2'd2;
      2'd1:    choice_next = 2'd0;
      default: choice_next = 2'd1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= S_INIT;
      init_idx_reg   <= '0;
      ctx_reg        <= '0;
      hist_fill_reg  <= '0;
      rounds_reg     <= '0;
      choice_reg     <= 2'd0;
      cur_counts_reg <= '0;
      illegal_reg    <= 1'b0;
      user_reg       <= 2'd0;
      rnd_reg        <= 2'd0;
    end else begin
      rnd_reg     <= (rnd_reg == 2'd2) ? 2'd0 : rnd_reg + 2'd1;
      illegal_reg <= 1'b0;
      case (state_reg)
        S_INIT: begin
          init_idx_reg <= init_idx_reg + CTX_W'(1);
          if (init_idx_reg == CTX_W'(ROWS - 1)) state_reg <= S_PREDICT;
        end
        S_PREDICT: begin
          choice_reg     <= choice_next;
          cur_counts_reg <= row_q;
          state_reg      <= S_IDLE;
        end
        S_IDLE: begin
          if (move_valid) begin
            if (user_move == 2'b11) begin
              illegal_reg <= 1'b1;
            end else begin
              user_reg  <= user_move;
              state_reg <= S_UPDATE;
            end
          end
        end
        S_UPDATE: begin
          ctx_reg       <= ctx_next;
          hist_fill_reg <= hist_full ? hist_fill_reg : hist_fill_reg + HF_W'(1);
          rounds_reg    <= (&rounds_reg) ? rounds_reg : rounds_reg + ROUND_W'(1);
          state_reg     <= S_PREDICT;
        end
        default: state_reg <= S_INIT;
      endcase
    end
  end

  assign choice_valid = (state_reg == S_IDLE);
  assign move_ready   = choice_valid;
  assign choice       = choice_reg;
  assign illegal_move = illegal_reg;
  assign rounds       = rounds_reg;
  assign cur_counts   = cur_counts_reg;
endmodule

// File: tb/tb_markov_predictor_n.sv
// Self-checking bench for markov_predictor_n against a round-level reference of the predictor.
module tb_markov_predictor_n;
  localparam int ORDER   = 1;
  localparam int COUNT_W = 2;
  localparam int ROUND_W = 16;
  localparam int ROWS    = 9 ** ORDER;
  localparam int CMAX    = (1 << COUNT_W) - 1;
  localparam int RMAX    = (1 << ROUND_W) - 1;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 move_valid = 1'b0;
  logic [1:0]           user_move = 2'd0;
  logic                 move_ready;
  logic [1:0]           choice;
  logic                 choice_valid;
  logic                 illegal_move;
  logic [ROUND_W-1:0]   rounds;
  logic [3*COUNT_W-1:0] cur_counts;

  markov_predictor_n #(.ORDER(ORDER), .COUNT_W(COUNT_W), .ROUND_W(ROUND_W)) dut (
    .clock(clock), .reset(reset), .move_valid(move_valid), .user_move(user_move),
    .move_ready(move_ready), .choice(choice), .choice_valid(choice_valid),
    .illegal_move(illegal_move), .rounds(rounds), .cur_counts(cur_counts)
  );

  always #5 clock = ~clock;

  // Cycle index since the last reset edge; the random source is this index mod 3.
  int cyc = 0;
  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  int checks = 0;
  int errors = 0;

  int tbl [ROWS][3];
  int m_ctx, m_hist, m_rounds, m_choice;
  int m_cnt [3];

  task automatic model_predict(input int r);
    int mx, nmax, lo, hi, pred;
    for (int i = 0; i < 3; i++) m_cnt[i] = tbl[m_ctx][i];
    mx = 0; nmax = 0; lo = -1; hi = -1;
    for (int i = 0; i < 3; i++) if (m_cnt[i] > mx) mx = m_cnt[i];
    for (int i = 0; i < 3; i++) if (m_cnt[i] == mx) begin
      nmax++;
      if (lo < 0) lo = i;
      hi = i;
    end
    if (m_hist < ORDER || mx == 0) pred = r;
    else if (nmax == 1) pred = lo;
    else if (nmax == 2) pred = (r % 2 == 0) ? lo : hi;
    else pred = r;
    m_choice = (pred + 2) % 3;
  endtask

  task automatic model_reset();
    for (int i = 0; i < ROWS; i++) for (int j = 0; j < 3; j++) tbl[i][j] = 0;
    m_ctx = 0; m_hist = 0; m_rounds = 0; m_choice = 0;
    model_predict(ROWS % 3);
  endtask

  task automatic model_update(input int u, input int r);
    if (m_hist == ORDER) begin
      if (tbl[m_ctx][u] == CMAX) begin
`ifdef MARKOV_DECAY_EN
        for (int j = 0; j < 3; j++) tbl[m_ctx][j] = tbl[m_ctx][j] / 2;
        tbl[m_ctx][u] = tbl[m_ctx][u] + 1;
`endif
      end else begin
        tbl[m_ctx][u] = tbl[m_ctx][u] + 1;
      end
    end
    m_ctx    = (m_ctx * 9 + u * 3 + m_choice) % ROWS;
    m_hist   = (m_hist < ORDER) ? m_hist + 1 : ORDER;
    m_rounds = (m_rounds < RMAX) ? m_rounds + 1 : RMAX;
    model_predict(r);
  endtask

  function automatic logic [3*COUNT_W-1:0] exp_counts();
    return {COUNT_W'(m_cnt[2]), COUNT_W'(m_cnt[1]), COUNT_W'(m_cnt[0])};
  endfunction

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    move_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // Starts on cycle 0 after reset release and ends on the first IDLE cycle.
  task automatic check_init_window();
    for (int k = 0; k <= ROWS + 1; k++) begin
      checks++;
      if (choice_valid !== (k == ROWS + 1)) begin
        errors++;
        $display("FAIL init_valid cycle %0d: choice_valid=%b required %b", k, choice_valid, k == ROWS + 1);
      end
      if (k <= ROWS) begin
        checks++;
        if (move_ready !== 1'b0 || cur_counts !== '0 || rounds !== '0) begin
          errors++;
          $display("FAIL init_state cycle %0d: ready=%b counts=%h rounds=%0d required 0/0/0", k, move_ready, cur_counts, rounds);
        end
        @(negedge clock);
      end
    end
    checks++;
    if (choice !== 2'(m_choice) || cur_counts !== '0) begin
      errors++;
      $display("FAIL init_choice: choice=%0d counts=%h required %0d/0", choice, cur_counts, m_choice);
    end
  endtask

  task automatic wait_ready(output bit ok);
    int w;
    w = 0;
    while (move_ready !== 1'b1 && w < 64) begin
      @(negedge clock);
      w++;
    end
    ok = (move_ready === 1'b1);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ready_timeout: move_ready=%b required 1", move_ready);
    end
  endtask

  task automatic play_round(input int mv, input int gap, output int seen);
    bit ok;
    int t;
    seen = -1;
    wait_ready(ok);
    if (!ok) return;
    for (int g = 0; g < gap; g++) @(negedge clock);
    seen = int'(choice);
    checks++;
    if (choice !== 2'(m_choice) || cur_counts !== exp_counts() || rounds !== ROUND_W'(m_rounds)) begin
      errors++;
      $display("FAIL round_state: choice=%0d counts=%h rounds=%0d required %0d/%h/%0d",
               choice, cur_counts, rounds, m_choice, exp_counts(), m_rounds);
    end
    $display("round: move=%0d choice=%0d counts=%h rounds=%0d", mv, choice, cur_counts, rounds);
    move_valid = 1'b1;
    user_move  = 2'(mv);
    t = cyc;
    @(negedge clock);
    move_valid = 1'b0;
    checks++;
    if (mv == 3) begin
      if (illegal_move !== 1'b1 || move_ready !== 1'b1) begin
        errors++;
        $display("FAIL illegal_ack: illegal_move=%b move_ready=%b required 1/1", illegal_move, move_ready);
      end
    end else begin
      if (choice_valid !== 1'b0 || illegal_move !== 1'b0) begin
        errors++;
        $display("FAIL accept: choice_valid=%b illegal_move=%b required 0/0", choice_valid, illegal_move);
      end
      model_update(mv, (t + 2) % 3);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_init_window();
  endtask

  task automatic test_saturation();
    int seen;
    bit ok;
    int sat_exp;
`ifdef MARKOV_DECAY_EN
    sat_exp = 2;
`else
    sat_exp = 3;
`endif
    apply_reset();
    for (int r = 0; r < 5; r++) play_round(0, 0, seen);
    wait_ready(ok);
    checks++;
    if (cur_counts[COUNT_W-1:0] !== COUNT_W'(sat_exp)) begin
      errors++;
      $display("FAIL saturation: rock=%0d required %0d", cur_counts[COUNT_W-1:0], sat_exp);
    end
  endtask

  task automatic test_learning();
    int seen;
    bit ok;
    apply_reset();
    for (int r = 1; r <= 20; r++) begin
      play_round(0, 0, seen);
      if (r >= 5) begin
        checks++;
        if (seen != 2) begin
          errors++;
          $display("FAIL learn_choice round %0d: choice=%0d required 2", r, seen);
        end
      end
    end
    wait_ready(ok);
    checks++;
    if (rounds !== ROUND_W'(20) || cur_counts[COUNT_W-1:0] === '0) begin
      errors++;
      $display("FAIL learn_end: rounds=%0d rock=%0d required 20/nonzero", rounds, cur_counts[COUNT_W-1:0]);
    end
  endtask

  task automatic test_illegal();
    bit ok;
    wait_ready(ok);
    move_valid = 1'b1;
    user_move  = 2'b11;
    @(negedge clock);
    move_valid = 1'b0;
    user_move  = 2'b00;
    checks++;
    if (illegal_move !== 1'b1 || move_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_pulse: illegal_move=%b move_ready=%b required 1/1", illegal_move, move_ready);
    end
    @(negedge clock);
    checks++;
    if (illegal_move !== 1'b0 || move_ready !== 1'b1 || choice !== 2'(m_choice) ||
        cur_counts !== exp_counts() || rounds !== ROUND_W'(m_rounds)) begin
      errors++;
      $display("FAIL illegal_hold: pulse=%b ready=%b choice=%0d counts=%h rounds=%0d required 0/1/%0d/%h/%0d",
               illegal_move, move_ready, choice, cur_counts, rounds, m_choice, exp_counts(), m_rounds);
    end
    $display("illegal: choice=%0d rounds=%0d", choice, rounds);
  endtask

  task automatic test_random();
    int seen, r, mv;
    for (int n = 0; n < 60; n++) begin
      r  = int'($urandom_range(0, 7));
      mv = (r == 7) ? 3 : r % 3;
      play_round(mv, int'($urandom_range(0, 3)), seen);
    end
  endtask

  task automatic test_throughput();
    bit ok;
    int hs, mv;
    hs = 0;
    wait_ready(ok);
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (choice_valid !== (i % 3 == 0) || illegal_move !== 1'b0) begin
        errors++;
        $display("FAIL tput_pattern cycle %0d: choice_valid=%b illegal=%b required %b/0", i, choice_valid, illegal_move, i % 3 == 0);
      end
      if (move_ready === 1'b1) begin
        checks++;
        if (choice !== 2'(m_choice) || cur_counts !== exp_counts()) begin
          errors++;
          $display("FAIL tput_choice: choice=%0d counts=%h required %0d/%h", choice, cur_counts, m_choice, exp_counts());
        end
        mv = int'($urandom_range(0, 2));
        $display("tput: move=%0d choice=%0d", mv, choice);
        user_move = 2'(mv);
        move_valid = 1'b1;
        hs++;
        model_update(mv, (cyc + 2) % 3);
      end else begin
        user_move = 2'($urandom_range(0, 3));
      end
      @(negedge clock);
    end
    move_valid = 1'b0;
    checks++;
    if (hs != 10) begin
      errors++;
      $display("FAIL tput_count: handshakes=%0d required 10", hs);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int seen;
    wait_ready(ok);
    move_valid = 1'b1;
    user_move  = 2'($urandom_range(0, 2));
    @(negedge clock);
    move_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (move_ready !== 1'b0 || rounds !== '0 || choice_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b rounds=%0d valid=%b required 0/0/0", move_ready, rounds, choice_valid);
    end
    reset = 1'b0;
    model_reset();
    check_init_window();
    for (int n = 0; n < 8; n++) play_round(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), seen);
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_learning();
    test_illegal();
    test_random();
    test_throughput();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
